// File: rtl/universal_sr_pkg.sv
// Mode encoding shared by the universal shift register and its bit-slice cells.
package universal_sr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    // sel is declared [0:1] with sel[0] as the MSB, so the bits are reordered explicitly.
    function automatic mode_t to_mode(input logic [0:1] sel);
        return mode_t'({sel[0], sel[1]});
    endfunction

endpackage

// File: rtl/usr_cell.sv
// One bit slice: 4:1 mux (hold, right neighbour, left neighbour, parallel bit) feeding a flop
// with synchronous active-high clear.
module usr_cell
    import universal_sr_pkg::*;
(
    input  logic  clk,
    input  logic  clr,
    input  mode_t mode,
    input  logic  right_in,
    input  logic  left_in,
    input  logic  par_in,
    output logic  q
);

    logic next_q;

    always_comb begin
        next_q = q;
        unique case (mode)
            MODE_HOLD: next_q = q;
            MODE_SHR:  next_q = right_in;
            MODE_SHL:  next_q = left_in;
            MODE_LOAD: next_q = par_in;
            default:   next_q = q;
        endcase
    end

    // NOTE: clear has priority over every mode and is sampled only on the clock edge.
    always_ff @(posedge clk) begin
        if (clr) q <= 1'b0;
        else     q <= next_q;
    end

endmodule

// File: rtl/universal_sr.sv
// Universal shift register: hold, shift right, shift left, parallel load.
// Define UNIVERSAL_SR_ROTATE_EN to make shifts rotate instead of taking serial-in from M.
module universal_sr
    import universal_sr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clr,
    input  logic             clk,
    input  logic [0:1]       sel,
    input  logic [WIDTH-1:0] M,
    output logic [WIDTH-1:0] Q
);

    mode_t            mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] right_src;
    logic [WIDTH-1:0] left_src;

    assign mode = to_mode(sel);

`ifdef UNIVERSAL_SR_ROTATE_EN
    assign sin_r = Q[0];
    assign sin_l = Q[WIDTH-1];
`else
    assign sin_r = M[WIDTH-1];
    assign sin_l = M[0];
`endif

    // Per-bit source for each shift direction, with serial-in at the open end.
    assign right_src = {sin_r, Q[WIDTH-1:1]};
    assign left_src  = {Q[WIDTH-2:0], sin_l};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        usr_cell u_cell (
            .clk      (clk),
            .clr      (clr),
            .mode     (mode),
            .right_in (right_src[i]),
            .left_in  (left_src[i]),
            .par_in   (M[i]),
            .q        (Q[i])
        );
    end

endmodule

// File: tb/tb_universal_sr.sv
// Scoreboard bench for universal_sr: directed sequences from the requirements, then random traffic
// checked against an arithmetic reference model.
module tb_universal_sr;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic [0:1]   sel = 2'b00;
    logic [W-1:0] M   = '0;
    logic [W-1:0] Q;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    logic [W-1:0] model_q;
    int           n_cmp = 0;
    int           n_err = 0;

    universal_sr #(.WIDTH(W)) dut (
        .clr (clr),
        .clk (clk),
        .sel (sel),
        .M   (M),
        .Q   (Q)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: Q=%b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: the register viewed as an integer; shifts are divide/multiply by two.
    function automatic logic [W-1:0] model_next(input logic [W-1:0] q, input logic c,
                                                input logic [0:1] s, input logic [W-1:0] m);
        int unsigned qi   = int'(q);
        int unsigned mi   = int'(m);
        int unsigned full = (1 << W) - 1;
        int unsigned code = {s[0], s[1]};
        int unsigned in_r, in_l;
`ifdef UNIVERSAL_SR_ROTATE_EN
        in_r = qi % 2;
        in_l = qi / (1 << (W - 1));
`else
        in_r = mi / (1 << (W - 1));
        in_l = mi % 2;
`endif
        if (c) return '0;
        case (code)
            0:       return q;
            1:       return W'(qi / 2 + in_r * (1 << (W - 1)));
            2:       return W'((qi * 2 + in_l) & full);
            default: return m;
        endcase
    endfunction

    // Directed step: expectation comes from the requirement table; the model is resynced to it.
    task automatic step_lit(input logic c, input logic [0:1] s, input logic [W-1:0] m,
                            input logic [W-1:0] expected, input string name);
        @(negedge clk);
        clr = c; sel = s; M = m;
        model_q = expected;
        exp_q.push_back(expected);
        tag_q.push_back(name);
    endtask

    task automatic step_rand(input logic c, input logic [0:1] s, input logic [W-1:0] m);
        @(negedge clk);
        clr = c; sel = s; M = m;
        model_q = model_next(model_q, c, s, m);
        exp_q.push_back(model_q);
        tag_q.push_back("random");
    endtask

    // Monitor: Q is registered, so every edge produces one response to compare.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) check(tag_q.pop_front(), Q, exp_q.pop_front());
        end
    end

    initial begin
        logic [W-1:0] shl_second;
        int           drain;
`ifdef UNIVERSAL_SR_ROTATE_EN
        shl_second = 4'b1110;
`else
        shl_second = 4'b1111;
`endif
        model_q = '0;

        step_lit(1, 2'b11, 4'b1011, 4'b0000, "reset_over_load");
        step_lit(0, 2'b11, 4'b1011, 4'b1011, "load");
        for (int i = 0; i < 3; i++) step_lit(0, 2'b00, 4'b1011, 4'b1011, "hold");
        step_lit(0, 2'b01, 4'b1011, 4'b1101, "shr_1");
        step_lit(0, 2'b01, 4'b1011, 4'b1110, "shr_2");
        step_lit(0, 2'b11, 4'b1011, 4'b1011, "reload_a");
        step_lit(0, 2'b10, 4'b1011, 4'b0111, "shl_1");
        step_lit(0, 2'b10, 4'b1011, shl_second, "shl_2");
        step_lit(0, 2'b11, 4'b1011, 4'b1011, "reload_b");
        step_lit(0, 2'b10, 4'b1011, 4'b0111, "shl_before_clr");
        step_lit(1, 2'b10, 4'b1011, 4'b0000, "clr_mid_shift");
        step_lit(0, 2'b11, 4'b0101, 4'b0101, "resume_load");
        step_lit(0, 2'b11, 4'b1011, 4'b1011, "b2b_load");
        step_lit(0, 2'b01, 4'b1011, 4'b1101, "b2b_shr");
        step_lit(0, 2'b10, 4'b1011, 4'b1011, "b2b_shl");
        step_lit(0, 2'b00, 4'b1011, 4'b1011, "b2b_hold");

        for (int i = 0; i < 300; i++)
            step_rand(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)), W'($urandom));

        drain = 0;
        while (exp_q.size() > 0 && drain < 5) begin
            @(posedge clk);
            drain++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/universal_sr.md
UNIVERSAL_SR -- requirements
Module: universal_sr

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 4, register width in bits (legal range 2..64).
REQ-002 Port `clk`: input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 Port `clr`: input, 1 bit, reset; synchronous and active-high.
REQ-004 Port `sel`: input, 2 bits, declared [0:1] with sel[0] as the MSB; selects the mode.
REQ-005 Port `M`: input, WIDTH bits, [WIDTH-1:0]; parallel-load data, also the source of serial-in bits.
REQ-006 Port `Q`: output, WIDTH bits, [WIDTH-1:0]; registered contents.
REQ-007 Port declaration order SHALL be clr, clk, sel, M, Q, so that positional instantiation works.

Function
REQ-008 sel=00 (HOLD) SHALL keep Q unchanged.
REQ-009 sel=01 (SHIFT RIGHT) SHALL load Q <= {SIN_R, Q[WIDTH-1:1]}.
  - SIN_R = M[WIDTH-1] by default.
REQ-010 sel=10 (SHIFT LEFT) SHALL load Q <= {Q[WIDTH-2:0], SIN_L}.
  - SIN_L = M[0] by default.
REQ-011 sel=11 (LOAD) SHALL load Q <= M.
REQ-012 Latency SHALL be exactly one clock: the new Q is visible after the rising edge that samples sel/M.
REQ-013 There SHALL be no combinational path from inputs to Q.
REQ-014 Mode changes SHALL take effect on the next edge with no idle cycle.
REQ-015 Shifts SHALL not saturate: bits shifted out are discarded, and a shift runs every cycle while sel holds a shift code.
REQ-016 sel or M containing X/Z SHALL not be required to produce defined Q.
  - The bench SHALL never drive X/Z on sel or M after reset.

Reset
REQ-017 When clr=1 at a rising clk edge, Q SHALL become all zeros regardless of sel and M.
REQ-018 clr SHALL have priority over every mode.
REQ-019 A reset asserted mid-shift SHALL abort the shift and zero Q on that edge.
REQ-020 Operation SHALL resume on the first edge with clr=0.
REQ-021 Before the first reset edge, Q is undefined.

Configuration
REQ-022 Macro UNIVERSAL_SR_ROTATE_EN: when defined, shifts SHALL rotate instead of taking serial-in from M.
  - SIN_R = Q[0].
  - SIN_L = Q[WIDTH-1].
REQ-023 When UNIVERSAL_SR_ROTATE_EN is undefined, serial-in SHALL come from M as specified in REQ-009 and REQ-010.

Structure
REQ-024 A shared package universal_sr_pkg SHALL hold the mode constants and the mode typedef.
  - Constants: MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
  - Typedef: 2-bit mode type.
REQ-025 One sub-module usr_cell SHALL implement one bit slice.
  - Contents: a 4:1 mux (hold, right neighbour, left neighbour, parallel bit) plus a flop with synchronous clear.
  - universal_sr instantiates WIDTH copies in a generate loop and wires the edge cells to SIN_R/SIN_L.

Verification (WIDTH=4, clk period 20 ns)
REQ-026 clr=1 for one edge, sel=11, M=1011 -> Q=0000.
REQ-027 clr=0, sel=11, M=1011 -> Q=1011 after 1 edge; then sel=00 for 3 edges -> Q stays 1011.
REQ-028 From Q=1011, sel=01, M=1011 -> Q=1101, then 1110.
  - With UNIVERSAL_SR_ROTATE_EN: also 1101, then 1110.
REQ-029 From Q=1011, sel=10, M=1011 -> Q=0111, then 1111.
  - With UNIVERSAL_SR_ROTATE_EN: 0111, then 1110.
REQ-030 From Q=1011, sel=10 with clr=1 on the second edge -> Q=0111, then 0000.
  - Then clr=0, sel=11, M=0101 -> Q=0101.
REQ-031 Back-to-back modes, one edge each, M=1011: 11, 01, 10, 00 -> Q=1011, 1101, 1011, 1011.
